conv_weight_scheduler: RTL and testbench
========================================

CONV_WEIGHT_SCHEDULER -- requirements
Module: conv_weight_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of conv-layer requesters sharing one weight BROM.
REQ-002 SHALL have parameter ROWS_PER_KERNEL, default 9: weight rows per kernel burst.
REQ-003 SHALL have parameter ROW_WIDTH, default 162: BROM word width (9 x 18-bit signed weights).
REQ-004 SHALL have parameter READ_LATENCY, default 2: BROM address-to-data cycles (HIGH_PERFORMANCE mode).
REQ-005 SHALL have parameter ADDR_WIDTH, default 6: BROM address width.
REQ-006 SHALL have port clk_in, input, 1: system clock; the only clock.
REQ-007 SHALL have port rst_in, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port req_in, input, NUM_REQ: level request for one kernel burst, one bit per requester.
REQ-009 SHALL have port ack_out, output, NUM_REQ: one-cycle acceptance pulse for the granted requester.
REQ-010 SHALL have port rom_addr_out, output, ADDR_WIDTH: BROM read address.
REQ-011 SHALL have port rom_data_in, input, ROW_WIDTH: BROM read data.
REQ-012 SHALL have port row_data_out, output, ROW_WIDTH: weight row, registered copy of rom_data_in.
REQ-013 SHALL have port row_valid_out, output, 1: row_data_out holds valid data.
REQ-014 SHALL have port row_id_out, output, $clog2(NUM_REQ): requester owning the current row.
REQ-015 SHALL have port row_num_out, output, 4: row index 0..ROWS_PER_KERNEL-1 within the burst.
REQ-016 SHALL have port done_out, output, NUM_REQ: one-cycle pulse coincident with the last row of a burst.

Function
REQ-017 SHALL run an FSM with states IDLE and ISSUE.
REQ-018 IDLE: with any req_in bit high, SHALL grant by round-robin starting after the last granted index, pulse ack_out[grant], and enter ISSUE in the same clock edge.
REQ-019 ISSUE: SHALL drive rom_addr_out = BASE_ADDR[grant] + row counter, with the counter stepping 0..ROWS_PER_KERNEL-1, one address per cycle, no gaps.
REQ-020 On issuing the final row, SHALL re-arbitrate in the same cycle: if any request is pending, the next burst starts on the following cycle (back-to-back), otherwise the FSM returns to IDLE.
REQ-021 A requester's req_in SHALL be ignored from its ack until its done_out; if req_in is still high after done_out, it SHALL be treated as a new request.
REQ-022 SHALL carry valid, id, and row tags through a shift pipeline of depth READ_LATENCY, then register them with rom_data_in into the outputs; issue-to-row_valid_out latency is READ_LATENCY+1 cycles.
REQ-023 done_out[id] SHALL assert only with row_num_out == ROWS_PER_KERNEL-1 and row_valid_out high.
REQ-024 Requests arriving mid-burst SHALL wait; the grant SHALL never change mid-burst; simultaneous requests SHALL resolve by round-robin pointer, with index 0 first after reset.
REQ-025 rom_addr_out SHALL hold its last value while IDLE; row_data_out is don't-care when row_valid_out is low.

Reset
REQ-026 rst_in high SHALL immediately force: FSM=IDLE, round-robin pointer=0, row counter=0, all pipeline valids=0, ack_out=0, done_out=0, row_valid_out=0, row_id_out=0, row_num_out=0, rom_addr_out=0, row_data_out=0.
REQ-027 A reset mid-burst SHALL discard in-flight rows with no done_out; requesters SHALL re-request.

Structure
REQ-028 Package conv_weight_pkg SHALL hold the BASE_ADDR table (layer i kernel = rows i*9..i*9+8), ROWS_PER_KERNEL, ROW_WIDTH, and the FSM state enum.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, advance strobe -> one-hot grant plus index); the BROM stays outside this block.

Verification
REQ-030 Single req_in=3'b001 held one cycle -> ack_out[0] next edge; rom_addr_out 0..8 on consecutive cycles; row_valid_out 9 cycles with row_num 0..8, id 0, starting 3 cycles after the first address; done_out[0] with row 8.
REQ-031 req_in=3'b111 simultaneously -> bursts granted in order 0,1,2 back-to-back; 27 contiguous row_valid_out cycles; addresses 0..26.
REQ-032 req_in[2] raised during burst 0 while req_in[1] stays low -> burst 2 starts the cycle after row 8 is issued, with no idle gap.
REQ-033 req_in[0] held high continuously with req_in[1] high -> grants alternate 0,1,0,1; no starvation.
REQ-034 rst_in pulsed at row 4 of a burst -> all outputs 0 asynchronously, no done_out, and the next request is granted from index 0.
REQ-035 A BROM model returning the address as data -> row_data_out[5:0] == BASE_ADDR[id] + row_num on every valid row.

Source files
------------

// File: rtl/conv_weight_scheduler_pkg.sv
// Shared constants, weight-ROM layout and scheduler state encoding.
// Kernel i occupies ROM rows i*ROWS_PER_KERNEL .. i*ROWS_PER_KERNEL+ROWS_PER_KERNEL-1.
package conv_weight_pkg;

    localparam int ROWS_PER_KERNEL = 9;
    localparam int ROW_WIDTH       = 162;
    localparam int MAX_REQ         = 8;

    localparam int BASE_ADDR [MAX_REQ] = '{0, 9, 18, 27, 36, 45, 54, 63};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/conv_weight_scheduler_if.sv
// Requester handshake, weight-ROM port and weight-row output bundle of the scheduler.
// master = requesters/ROM side, slave = scheduler.
interface conv_weight_scheduler_if #(
    parameter int NUM_REQ    = 3,
    parameter int ROW_WIDTH  = conv_weight_pkg::ROW_WIDTH,
    parameter int ADDR_WIDTH = 6,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]    req_in;
    logic [NUM_REQ-1:0]    ack_out;
    logic [ADDR_WIDTH-1:0] rom_addr_out;
    logic [ROW_WIDTH-1:0]  rom_data_in;
    logic [ROW_WIDTH-1:0]  row_data_out;
    logic                  row_valid_out;
    logic [ID_WIDTH-1:0]   row_id_out;
    logic [3:0]            row_num_out;
    logic [NUM_REQ-1:0]    done_out;

    modport master (
        output req_in, rom_data_in,
        input  ack_out, rom_addr_out, row_data_out, row_valid_out,
               row_id_out, row_num_out, done_out
    );

    modport slave (
        input  req_in, rom_data_in,
        output ack_out, rom_addr_out, row_data_out, row_valid_out,
               row_id_out, row_num_out, done_out
    );
endinterface

// File: rtl/conv_weight_scheduler_rr_arbiter.sv
// Round-robin picker: combinational one-hot grant and index from the request vector.
// The search pointer moves to one past the granted index on each advance strobe.
module rr_arbiter #(
    parameter int N         = 3,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 any
);

    logic [IDX_WIDTH-1:0] ptr;
    int                   cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant_idx   = IDX_WIDTH'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/conv_weight_scheduler.sv
// Arbitrates conv-layer requesters onto one weight ROM and streams 9-row kernel bursts, one row per cycle.
// Row output trails the issued address by READ_LATENCY+1 cycles; requests wait while a burst is in progress.
module conv_weight_scheduler #(
    parameter int NUM_REQ         = 3,
    parameter int ROWS_PER_KERNEL = conv_weight_pkg::ROWS_PER_KERNEL,
    parameter int ROW_WIDTH       = conv_weight_pkg::ROW_WIDTH,
    parameter int READ_LATENCY    = 2,
    parameter int ADDR_WIDTH      = 6
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    conv_weight_scheduler_if.slave  bus
);
    import conv_weight_pkg::*;

    localparam int         ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] LAST_ROW = 4'(ROWS_PER_KERNEL - 1);

    state_t                state, state_nxt;
    logic [NUM_REQ-1:0]    busy, eff_req, gnt_oh, ack_q, done_q, done_nxt;
    logic [ID_WIDTH-1:0]   gnt_idx, cur_id;
    logic                  gnt_any, grant_now, last_row;
    logic [3:0]            row_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  pv   [READ_LATENCY];
    logic [ID_WIDTH-1:0]   pid  [READ_LATENCY];
    logic [3:0]            prow [READ_LATENCY];

    logic                  row_vld_q;
    logic [ID_WIDTH-1:0]   row_id_q;
    logic [3:0]            row_num_q;
    logic [ROW_WIDTH-1:0]  row_dat_q;

    function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [ID_WIDTH-1:0] id,
                                                       input logic [3:0] row);
        return ADDR_WIDTH'(BASE_ADDR[int'(id)] + int'(row));
    endfunction

    // A requester stays masked from its ack until its last row leaves the pipeline.
    assign eff_req  = bus.req_in & ~busy;
    assign last_row = (row_cnt == LAST_ROW);

    rr_arbiter #(
        .N         (NUM_REQ),
        .IDX_WIDTH (ID_WIDTH)
    ) u_arb (
        .clk       (clk_in),
        .rst       (rst_in),
        .req       (eff_req),
        .advance   (grant_now),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx),
        .any       (gnt_any)
    );

    always_comb begin
        state_nxt = state;
        grant_now = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    grant_now = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (last_row) begin
                    if (gnt_any) grant_now = 1'b1;
                    else         state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ack_q   <= '0;
            cur_id  <= '0;
            row_cnt <= '0;
            addr_q  <= '0;
        end else begin
            ack_q <= grant_now ? gnt_oh : '0;
            if (grant_now) begin
                cur_id  <= gnt_idx;
                row_cnt <= '0;
                addr_q  <= row_addr(gnt_idx, 4'd0);
            end else if (state == ST_ISSUE && !last_row) begin
                row_cnt <= row_cnt + 4'd1;
                addr_q  <= row_addr(cur_id, row_cnt + 4'd1);
            end else if (state == ST_ISSUE) begin
                row_cnt <= '0;
            end
        end
    end

    // Tags ride alongside the ROM read so they line up with rom_data_in.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pv[k]   <= 1'b0;
                pid[k]  <= '0;
                prow[k] <= '0;
            end
        end else begin
            pv[0]   <= (state == ST_ISSUE);
            pid[0]  <= cur_id;
            prow[0] <= row_cnt;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pv[k]   <= pv[k-1];
                pid[k]  <= pid[k-1];
                prow[k] <= prow[k-1];
            end
        end
    end

    assign done_nxt = (pv[READ_LATENCY-1] && prow[READ_LATENCY-1] == LAST_ROW)
                    ? (NUM_REQ'(1) << pid[READ_LATENCY-1]) : '0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            row_vld_q <= 1'b0;
            row_id_q  <= '0;
            row_num_q <= '0;
            row_dat_q <= '0;
            done_q    <= '0;
            busy      <= '0;
        end else begin
            row_vld_q <= pv[READ_LATENCY-1];
            row_id_q  <= pid[READ_LATENCY-1];
            row_num_q <= prow[READ_LATENCY-1];
            row_dat_q <= bus.rom_data_in;
            done_q    <= done_nxt;
            busy      <= (busy & ~done_nxt) | (grant_now ? gnt_oh : '0);
        end
    end

    assign bus.ack_out       = ack_q;
    assign bus.rom_addr_out  = addr_q;
    assign bus.row_valid_out = row_vld_q;
    assign bus.row_id_out    = row_id_q;
    assign bus.row_num_out   = row_num_q;
    assign bus.row_data_out  = row_dat_q;
    assign bus.done_out      = done_q;

endmodule

// File: tb/tb_conv_weight_scheduler.sv
// Directed bench for conv_weight_scheduler with a two-stage ROM model and a row scoreboard.
module tb_conv_weight_scheduler;

    localparam int NR  = 3;
    localparam int RW  = 162;
    localparam int AW  = 6;
    localparam int RPK = 9;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] row;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   run = 0;
    int   max_run = 0;
    int   row0_cyc = 0;
    exp_t sbq [$];

    logic [AW-1:0] rom_r1, rom_r2;

    conv_weight_scheduler_if #(.NUM_REQ(NR), .ROW_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

    conv_weight_scheduler #(
        .NUM_REQ         (NR),
        .ROWS_PER_KERNEL (RPK),
        .ROW_WIDTH       (RW),
        .READ_LATENCY    (2),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Two-cycle ROM; data word carries the address and its complement.
    always @(posedge clk) begin
        rom_r1 <= bus.rom_addr_out;
        rom_r2 <= rom_r1;
    end
    assign bus.rom_data_in = {{(RW-2*AW){1'b0}}, ~rom_r2, rom_r2};

    function automatic logic [RW-1:0] rowval(input int a);
        logic [AW-1:0] v;
        v = AW'(a);
        return {{(RW-2*AW){1'b0}}, ~v, v};
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int id);
        exp_t e;
        for (int r = 0; r < RPK; r++) begin
            e.id  = 2'(id);
            e.row = 4'(r);
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain", 192'(sbq.size()), 192'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   192'(bus.ack_out),       192'(0));
        chk({tag, "_addr"},  192'(bus.rom_addr_out),  192'(0));
        chk({tag, "_valid"}, 192'(bus.row_valid_out), 192'(0));
        chk({tag, "_id"},    192'(bus.row_id_out),    192'(0));
        chk({tag, "_num"},   192'(bus.row_num_out),   192'(0));
        chk({tag, "_done"},  192'(bus.done_out),      192'(0));
        chk({tag, "_data"},  192'(bus.row_data_out),  192'(0));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.row_valid_out) begin
            run++;
            if (run > max_run) max_run = run;
            if (bus.done_out != '0) done_cnt++;
            chk("sb_nonempty", 192'(sbq.size() != 0), 192'(1));
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("row_id",   192'(bus.row_id_out),   192'(e.id));
                chk("row_num",  192'(bus.row_num_out),  192'(e.row));
                chk("row_data", 192'(bus.row_data_out), 192'(rowval(int'(e.id) * RPK + int'(e.row))));
                chk("row_done", 192'(bus.done_out),
                    192'((e.row == 4'd8) ? (3'b001 << e.id) : 3'b000));
                if (e.row == 4'd0) row0_cyc = cyc;
            end
        end else begin
            run = 0;
            chk("done_idle", 192'(bus.done_out), 192'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int dc;
        bus.req_in = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Single burst from requester 0.
        @(negedge clk);
        bus.req_in = 3'b001;
        push_burst(0);
        @(negedge clk);
        chk("t1_ack", 192'(bus.ack_out), 192'(3'b001));
        chk("t1_addr0", 192'(bus.rom_addr_out), 192'(0));
        t0 = cyc;
        bus.req_in = '0;
        for (int r = 1; r < RPK; r++) begin
            @(negedge clk);
            chk("t1_addr", 192'(bus.rom_addr_out), 192'(r));
            chk("t1_ack_low", 192'(bus.ack_out), 192'(0));
        end
        drain();
        chk("t1_latency", 192'(row0_cyc - t0), 192'(3));
        chk("t1_addr_hold", 192'(bus.rom_addr_out), 192'(8));
        chk("t1_done_cnt", 192'(done_cnt), 192'(1));

        // All three at once: 0,1,2 back-to-back.
        do_reset();
        max_run = 0;
        bus.req_in = 3'b111;
        push_burst(0); push_burst(1); push_burst(2);
        for (int k = 0; k < 3 * RPK; k++) begin
            @(negedge clk);
            chk("t2_addr", 192'(bus.rom_addr_out), 192'(k));
            chk("t2_ack", 192'(bus.ack_out),
                192'((k % RPK == 0) ? (3'b001 << (k / RPK)) : 3'b000));
            bus.req_in = bus.req_in & ~bus.ack_out;
        end
        drain();
        chk("t2_contig", 192'(max_run), 192'(27));
        chk("t2_done_cnt", 192'(done_cnt), 192'(4));

        // Requester 2 arrives mid-burst and follows with no gap.
        do_reset();
        bus.req_in = 3'b001;
        push_burst(0); push_burst(2);
        for (int k = 0; k < 2 * RPK; k++) begin
            @(negedge clk);
            chk("t3_addr", 192'(bus.rom_addr_out), 192'((k < RPK) ? k : 18 + k - RPK));
            chk("t3_ack", 192'(bus.ack_out),
                192'((k == 0) ? 3'b001 : (k == RPK) ? 3'b100 : 3'b000));
            if (k == 0)   bus.req_in = 3'b000;
            if (k == 3)   bus.req_in = 3'b100;
            if (k == RPK) bus.req_in = 3'b000;
        end
        drain();
        chk("t3_done_cnt", 192'(done_cnt), 192'(6));

        // Requesters 0 and 1 held high: strict alternation.
        do_reset();
        bus.req_in = 3'b011;
        push_burst(0); push_burst(1); push_burst(0); push_burst(1);
        for (int k = 0; k < 4 * RPK; k++) begin
            @(negedge clk);
            chk("t4_addr", 192'(bus.rom_addr_out), 192'(((k / RPK) % 2) * RPK + k % RPK));
            chk("t4_ack", 192'(bus.ack_out),
                192'((k % RPK == 0) ? (3'b001 << ((k / RPK) % 2)) : 3'b000));
            if (k == 3 * RPK) bus.req_in = 3'b000;
        end
        drain();
        chk("t4_done_cnt", 192'(done_cnt), 192'(10));

        // Reset at row 4 of a burst from requester 1.
        do_reset();
        bus.req_in = 3'b010;
        for (int r = 0; r < 2; r++) begin
            exp_t e;
            e.id = 2'd1;
            e.row = 4'(r);
            sbq.push_back(e);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_addr", 192'(bus.rom_addr_out), 192'(RPK + k));
            if (k == 0) begin
                chk("t5_ack", 192'(bus.ack_out), 192'(3'b010));
                bus.req_in = 3'b000;
            end
        end
        #2 rst = 1'b1;
        #1 chk_all_zero("t5_async");
        dc = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t5_flush", 192'(sbq.size()), 192'(0));
        repeat (4) @(negedge clk);
        chk("t5_no_done", 192'(done_cnt), 192'(dc));
        bus.req_in = 3'b111;
        push_burst(0);
        @(negedge clk);
        chk("t5_regrant", 192'(bus.ack_out), 192'(3'b001));
        bus.req_in = 3'b000;
        drain();
        chk("t5_done_cnt", 192'(done_cnt), 192'(dc + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
